// File: rtl/nor_bus_arbiter.sv
// Round-robin arbiter and precharge/evaluate sequencer for a precharged wired-NOR bus.
// Optional macro NOR_BUS_PRECHARGE_CHECK_EN adds a sticky err output and checks the bus before EVAL.
module nor_bus_arbiter #(
   parameter int unsigned N_REQ            = 4,
   parameter int unsigned WIDTH            = 8,
   parameter int unsigned PRECHARGE_CYCLES = 1,
   parameter int unsigned EVAL_CYCLES      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             pchg,
   output logic [N_REQ-1:0] pd_en,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] rdata,
   output logic [N_REQ-1:0] done,
   output logic             busy
`ifdef NOR_BUS_PRECHARGE_CHECK_EN
   ,
   output logic             err
`endif
);

   localparam int unsigned IW   = $clog2(N_REQ);
   localparam int unsigned CMAX = (PRECHARGE_CYCLES > EVAL_CYCLES) ? PRECHARGE_CYCLES : EVAL_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRECHARGE,
      S_EVAL,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] r_pd_en;
   logic [N_REQ-1:0] r_done;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    r_ptr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rdata;
   logic             r_pchg;
   logic             r_busy;

   logic [N_REQ-1:0] w_req_m;
   logic [N_REQ-1:0] w_win_oh;
   logic [IW-1:0]    w_win_idx;
   logic             w_win_valid;
   logic             w_pre_ok;
   int unsigned      w_idx;

   // The completing owner is masked so it cannot win its own DONE arbitration.
   always_comb begin
      w_req_m = '0;
      case (r_state)
         S_IDLE:  w_req_m = req;
         S_DONE:  w_req_m = req & ~r_grant;
         default: w_req_m = '0;
      endcase
   end

   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_win_oh    = '0;
      w_idx       = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = 32'(r_ptr) + k;
         if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
         if (!w_win_valid && w_req_m[IW'(w_idx)]) begin
            w_win_valid            = 1'b1;
            w_win_idx              = IW'(w_idx);
            w_win_oh               = '0;
            w_win_oh[IW'(w_idx)]   = 1'b1;
         end
      end
   end

`ifdef NOR_BUS_PRECHARGE_CHECK_EN
   logic r_err;
   assign w_pre_ok = &bus_in;
   assign err      = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if (r_state == S_PRECHARGE && r_cnt == CW'(PRECHARGE_CYCLES - 1) && !w_pre_ok)
         r_err <= 1'b1;
   end
`else
   assign w_pre_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_pd_en <= '0;
         r_done  <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_pchg  <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_done <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_grant <= w_win_oh;
                  r_owner <= w_win_idx;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_PRECHARGE;
               end
            end
            S_PRECHARGE: begin
               if (r_cnt == CW'(PRECHARGE_CYCLES - 1)) begin
                  r_cnt <= '0;
                  // A failed bus check simply restarts the precharge window.
                  if (w_pre_ok) begin
                     r_pchg  <= 1'b0;
                     r_pd_en <= r_grant;
                     r_state <= S_EVAL;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_EVAL: begin
               if (r_cnt == CW'(EVAL_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_rdata <= bus_in;
                  r_pchg  <= 1'b1;
                  r_pd_en <= '0;
                  r_done  <= r_grant;
                  r_ptr   <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (w_win_valid) begin
                  r_grant <= w_win_oh;
                  r_owner <= w_win_idx;
                  r_cnt   <= '0;
                  r_state <= S_PRECHARGE;
               end else begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant = r_grant;
   assign pchg  = r_pchg;
   assign pd_en = r_pd_en;
   assign rdata = r_rdata;
   assign done  = r_done;
   assign busy  = r_busy;

endmodule

// File: tb/tb_nor_bus_arbiter.sv
// Directed self-checking bench for nor_bus_arbiter (default parameters).
module tb_nor_bus_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = 8;
   localparam int unsigned P     = 1;
   localparam int unsigned E     = 2;
   localparam int unsigned BOUND = N * (1 + P + E) + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         pchg;
   logic [N-1:0] pd_en;
   logic [W-1:0] bus_in;
   logic [W-1:0] rdata;
   logic [N-1:0] done;
   logic         busy;
`ifdef NOR_BUS_PRECHARGE_CHECK_EN
   logic         err;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned wt[N];
   logic [N-1:0] exp_g;

   always #5 clk = ~clk;

   nor_bus_arbiter #(
      .N_REQ            (N),
      .WIDTH            (W),
      .PRECHARGE_CYCLES (P),
      .EVAL_CYCLES      (E)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .grant  (grant),
      .pchg   (pchg),
      .pd_en  (pd_en),
      .bus_in (bus_in),
      .rdata  (rdata),
      .done   (done),
      .busy   (busy)
`ifdef NOR_BUS_PRECHARGE_CHECK_EN
      ,
      .err    (err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst    = 1'b1;
      req    = '0;
      bus_in = 8'hFF;
      tick();
      tick();
      chk("rst_grant", grant, 0);
      chk("rst_pd_en", pd_en, 0);
      chk("rst_done",  done,  0);
      chk("rst_rdata", rdata, 0);
      chk("rst_busy",  busy,  0);
      chk("rst_pchg",  pchg,  1);
`ifdef NOR_BUS_PRECHARGE_CHECK_EN
      chk("rst_err", err, 0);
`endif

      // single transaction, req dropped mid-transaction
      rst = 1'b0;
      req = 4'b0100;
      tick();
      chk("t1_grant",    grant, 4'b0100);
      chk("t1_pchg_pre", pchg,  1);
      chk("t1_pd_pre",   pd_en, 0);
      chk("t1_busy",     busy,  1);
      req = '0;
      tick();
      chk("t1_pchg_ev1", pchg,  0);
      chk("t1_pd_ev1",   pd_en, 4'b0100);
      bus_in = 8'h5A;
      tick();
      chk("t1_pchg_ev2", pchg,  0);
      chk("t1_pd_ev2",   pd_en, 4'b0100);
      chk("t1_rdata_old", rdata, 0);
      chk("t1_done_early", done, 0);
      tick();
      chk("t1_done",      done,  4'b0100);
      chk("t1_rdata",     rdata, 8'h5A);
      chk("t1_pchg_done", pchg,  1);
      chk("t1_pd_done",   pd_en, 0);
      bus_in = 8'hFF;
      tick();
      chk("t1_done_clr",   done,  0);
      chk("t1_grant_idle", grant, 0);
      chk("t1_busy_idle",  busy,  0);
      chk("t1_rdata_hold", rdata, 8'h5A);

      // pointer wrap: 3 completes, then 0 wins over 3
      req = 4'b1000;
      tick();
      chk("t3_grant3", grant, 4'b1000);
      tick(); tick(); tick();
      chk("t3_done3", done, 4'b1000);
      req = 4'b1001;
      tick();
      chk("t3_grant0", grant, 4'b0001);
      tick(); tick(); tick();
      chk("t3_done0", done, 4'b0001);
      req = 4'b1000;
      tick();
      chk("t3_grant3b", grant, 4'b1000);
      tick(); tick(); tick();
      chk("t3_done3b", done, 4'b1000);
      req = '0;
      tick();
      chk("t3_idle_grant", grant, 0);
      chk("t3_idle_busy",  busy,  0);

      // all requesting from reset: order 0,1,2,3, no idle gaps
      rst = 1'b1;
      req = 4'b1111;
      tick();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_g = 4'b0001 << k;
         chk("rr_grant", grant, exp_g);
         chk("rr_busy_pre", busy, 1);
         tick(); tick();
         chk("rr_pd_ev2", pd_en, exp_g);
         tick();
         chk("rr_done", done, exp_g);
         chk("rr_busy_done", busy, 1);
         tick();
      end
      chk("rr_grant_wrap", grant, 4'b0001);
      tick(); tick();
      chk("rr_pd_before_rst", pd_en, 4'b0001);
      chk("rr_pchg_before_rst", pchg, 0);

      // asynchronous reset in the second EVAL cycle
      rst = 1'b1;
      #1;
      chk("arst_pd_en", pd_en, 0);
      chk("arst_pchg",  pchg,  1);
      chk("arst_grant", grant, 0);
      chk("arst_busy",  busy,  0);
      req = '0;
      tick();
      rst = 1'b0;
      exp_g = '0;
      for (int k = 0; k < 6; k++) begin
         exp_g = exp_g | done;
         tick();
      end
      chk("arst_no_done", exp_g, 0);
      req = 4'b0010;
      tick();
      chk("arst_regrant", grant, 4'b0010);
      tick();
      bus_in = 8'hC3;
      tick(); tick();
      chk("arst_done",  done,  4'b0010);
      chk("arst_rdata", rdata, 8'hC3);
      req    = '0;
      bus_in = 8'hFF;
      tick();

      // random traffic with invariants and latency bound
      for (int i = 0; i < N; i++) wt[i] = 0;
      for (int c = 0; c < 10040; c++) begin
         chk("inv_pchg_pd", 32'(pchg & (|pd_en)), 0);
         chk("inv_onehot0", 32'($onehot0(grant)), 1);
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (done[i]) begin
                  chk("rnd_latency", 32'(wt[i] <= BOUND), 1);
                  req[i] = 1'b0;
               end else begin
                  wt[i]++;
                  if (wt[i] > BOUND) begin
                     chk("rnd_timeout", wt[i], BOUND);
                     req[i] = 1'b0;
                  end
               end
            end else begin
               if (done[i]) chk("rnd_spurious_done", 32'(i), 32'hFFFF);
               if (c < 10000 && $urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  wt[i]  = 0;
               end
            end
         end
         bus_in = pchg ? 8'hFF : 8'($urandom);
         tick();
      end
      chk("rnd_drained", req, 0);
      chk("rnd_idle", busy, 0);
      bus_in = 8'hFF;

`ifdef NOR_BUS_PRECHARGE_CHECK_EN
      req    = 4'b0001;
      bus_in = 8'hFE;
      tick();
      chk("pc_grant", grant, 4'b0001);
      chk("pc_err0",  err,   0);
      tick();
      chk("pc_err1",  err,   1);
      chk("pc_pchg",  pchg,  1);
      chk("pc_pd",    pd_en, 0);
      bus_in = 8'hFF;
      tick();
      chk("pc_eval_pd",   pd_en, 4'b0001);
      chk("pc_eval_pchg", pchg,  0);
      chk("pc_err_stay",  err,   1);
      req = '0;
      tick(); tick();
      chk("pc_done",      done,  4'b0001);
      chk("pc_err_final", err,   1);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
